// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared calc-type encodings, tag width and station size defaults
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif
`ifndef RS_SIZE
`define RS_SIZE 8
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef LUI
`define LUI 6'd1
`define AUIPC 6'd2
`define ADD 6'd3
`define ADDI 6'd4
`endif
package alu_rs_pkg;
  localparam int TYPE_W = `INST_TYPE_WIDTH;
  typedef logic [TYPE_W-1:0] itype_t;
  localparam itype_t T_LUI = `LUI;
  localparam itype_t T_AUIPC = `AUIPC;
  localparam itype_t T_ADD = `ADD;
  localparam itype_t T_ADDI = `ADDI;
endpackage

// File: rtl/rs_pick.sv
// rs_pick: lowest-index priority encoder returning a found bit and the winning index
module rs_pick #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station holding calc instructions until operands resolve, one dispatch per cycle
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = `RS_SIZE,
  parameter int ROB_WIDTH = `ROB_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        issue_valid,
  input  logic [`INST_TYPE_WIDTH-1:0] issue_type,
  input  logic [31:0]                 issue_vj,
  input  logic [31:0]                 issue_vk,
  input  logic [ROB_WIDTH-1:0]        issue_qj,
  input  logic [ROB_WIDTH-1:0]        issue_qk,
  input  logic                        issue_rj,
  input  logic                        issue_rk,
  input  logic [31:0]                 issue_imm,
  input  logic [31:0]                 issue_pc,
  input  logic [ROB_WIDTH-1:0]        issue_tag,
  output logic                        rs_full,
  input  logic                        alu_cdb_valid,
  input  logic [ROB_WIDTH-1:0]        alu_cdb_tag,
  input  logic [31:0]                 alu_cdb_val,
  input  logic                        lsb_cdb_valid,
  input  logic [ROB_WIDTH-1:0]        lsb_cdb_tag,
  input  logic [31:0]                 lsb_cdb_val,
  output logic                        alu_valid,
  output logic [`INST_TYPE_WIDTH-1:0] alu_type,
  output logic [31:0]                 alu_a,
  output logic [31:0]                 alu_b,
  output logic [31:0]                 alu_imm,
  output logic [31:0]                 alu_pc,
  output logic [ROB_WIDTH-1:0]        alu_tag
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy, rj, rk, ready;
  itype_t typ [RS_SIZE];
  logic [31:0] vj [RS_SIZE], vk [RS_SIZE], imm [RS_SIZE], pc [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj [RS_SIZE], qk [RS_SIZE], tag [RS_SIZE];
  logic free_found, sel_found;
  logic [IW-1:0] free_idx, sel_idx;
  logic aj, lj, ak, lk, in_rj, in_rk;
  logic [31:0] in_vj, in_vk;
  assign ready = busy & rj & rk;
  assign rs_full = &busy;
  rs_pick #(.N(RS_SIZE)) u_free (.req(~busy), .found(free_found), .idx(free_idx));
  rs_pick #(.N(RS_SIZE)) u_sel (.req(ready), .found(sel_found), .idx(sel_idx));
  // incoming operands snoop both buses so a same-cycle broadcast is captured
  always_comb begin
    aj = alu_cdb_valid && alu_cdb_tag == issue_qj;
    lj = lsb_cdb_valid && lsb_cdb_tag == issue_qj;
    ak = alu_cdb_valid && alu_cdb_tag == issue_qk;
    lk = lsb_cdb_valid && lsb_cdb_tag == issue_qk;
    in_rj = issue_rj || aj || lj;
    in_rk = issue_rk || ak || lk;
    in_vj = issue_rj ? issue_vj : aj ? alu_cdb_val : lsb_cdb_val;
    in_vk = issue_rk ? issue_vk : ak ? alu_cdb_val : lsb_cdb_val;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      alu_valid <= 1'b0;
      alu_type <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_imm <= '0;
      alu_pc <= '0;
      alu_tag <= '0;
    end else if (flush_in) begin
      busy <= '0;
      alu_valid <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !rj[i] && alu_cdb_valid && alu_cdb_tag == qj[i]) begin
          vj[i] <= alu_cdb_val;
          rj[i] <= 1'b1;
        end else if (busy[i] && !rj[i] && lsb_cdb_valid && lsb_cdb_tag == qj[i]) begin
          vj[i] <= lsb_cdb_val;
          rj[i] <= 1'b1;
        end
        if (busy[i] && !rk[i] && alu_cdb_valid && alu_cdb_tag == qk[i]) begin
          vk[i] <= alu_cdb_val;
          rk[i] <= 1'b1;
        end else if (busy[i] && !rk[i] && lsb_cdb_valid && lsb_cdb_tag == qk[i]) begin
          vk[i] <= lsb_cdb_val;
          rk[i] <= 1'b1;
        end
      end
      alu_valid <= sel_found;
      if (sel_found) begin
        alu_type <= typ[sel_idx];
        alu_a <= vj[sel_idx];
        alu_b <= vk[sel_idx];
        alu_imm <= imm[sel_idx];
        alu_pc <= pc[sel_idx];
        alu_tag <= tag[sel_idx];
        busy[sel_idx] <= 1'b0;
      end
      if (issue_valid && free_found) begin
        busy[free_idx] <= 1'b1;
        typ[free_idx] <= issue_type;
        vj[free_idx] <= in_vj;
        vk[free_idx] <= in_vk;
        qj[free_idx] <= issue_qj;
        qk[free_idx] <= issue_qk;
        rj[free_idx] <= in_rj;
        rk[free_idx] <= in_rk;
        imm[free_idx] <= issue_imm;
        pc[free_idx] <= issue_pc;
        tag[free_idx] <= issue_tag;
      end
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_in)
    assert (rst_in || flush_in || !rdy_in || !(issue_valid && rs_full))
      else $error("alu_rs: issue while rs_full, instruction dropped");
`endif
endmodule
